// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: access length codes,
// RISC-V memory funct3 encodings, fault codes, FSM states and store masking.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } len_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_ILLEGAL    = 2'b10
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Zero everything above the access length so memory never sees stale upper bits.
  function automatic logic [31:0] mask_store(input logic [1:0] len, input logic [31:0] d);
    logic [31:0] m;
    case (len)
      LEN_BYTE: m = {24'h0, d[7:0]};
      LEN_HALF: m = {16'h0, d[15:0]};
      LEN_WORD: m = d;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_decoder.sv
// Combinational decode of a memory request: funct3/direction to access length and
// sign control, plus alignment and legality checking. Faulted requests decode to no access.
module lsu_access_decoder
  import load_store_unit_pkg::*;
#(
  parameter bit ALLOW_MISAL = 1'b0
) (
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] addr_lo,
  output logic [1:0] length,
  output logic       is_signed,
  output logic [1:0] fault
);

  logic misaligned;

  // Illegal funct3 is resolved first so it always wins over misalignment.
  always_comb begin
    length    = LEN_NONE;
    is_signed = 1'b0;
    fault     = FAULT_NONE;
    if (is_store) begin
      case (funct3)
        F3_SB:   length = LEN_BYTE;
        F3_SH:   length = LEN_HALF;
        F3_SW:   length = LEN_WORD;
        default: fault  = FAULT_ILLEGAL;
      endcase
    end else begin
      case (funct3)
        F3_LB:   begin length = LEN_BYTE; is_signed = 1'b1; end
        F3_LH:   begin length = LEN_HALF; is_signed = 1'b1; end
        F3_LW:   length = LEN_WORD;
        F3_LBU:  length = LEN_BYTE;
        F3_LHU:  length = LEN_HALF;
        default: fault  = FAULT_ILLEGAL;
      endcase
    end
    misaligned = ((length == LEN_HALF) && addr_lo[0]) ||
                 ((length == LEN_WORD) && (addr_lo != 2'b00));
    if ((fault == FAULT_NONE) && misaligned && !ALLOW_MISAL) begin
      fault = FAULT_MISALIGNED;
    end
    if (fault != FAULT_NONE) begin
      length    = LEN_NONE;
      is_signed = 1'b0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, drives the memory
// ports from registered state, waits out the memory latency and returns a
// registered response to writeback.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 0,
  parameter bit          ALLOW_MISAL = 1'b0
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        LSU_req_valid,
  output logic        LSU_req_ready,
  input  logic        LSU_req_is_store,
  input  logic [2:0]  LSU_req_funct3,
  input  logic [31:0] LSU_req_address,
  input  logic [31:0] LSU_req_store_data,
  input  logic [4:0]  LSU_req_rd,
  output logic        LSU_resp_valid,
  input  logic        LSU_resp_ready,
  output logic [31:0] LSU_resp_load_data,
  output logic [4:0]  LSU_resp_rd,
  output logic        LSU_resp_is_store,
  output logic [1:0]  LSU_resp_fault,
  output logic [1:0]  MEM_write_length,
  output logic [1:0]  MEM_read_length,
  output logic        MEM_read_signed,
  output logic [31:0] MEM_write_data,
  output logic [31:0] MEM_write_address,
  output logic [31:0] MEM_read_address,
  input  logic [31:0] MEM_read_data
);

  localparam logic [2:0] CNT_INIT = (MEM_LATENCY == 0) ? 3'd0 : 3'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic [1:0]  len_q, len_d;
  logic        signed_q, signed_d;
  logic [1:0]  fault_q, fault_d;

  logic [1:0]  dec_length;
  logic        dec_signed;
  logic [1:0]  dec_fault;

  lsu_access_decoder #(
    .ALLOW_MISAL(ALLOW_MISAL)
  ) u_decoder (
    .funct3    (LSU_req_funct3),
    .is_store  (LSU_req_is_store),
    .addr_lo   (LSU_req_address[1:0]),
    .length    (dec_length),
    .is_signed (dec_signed),
    .fault     (dec_fault)
  );

  // Next-state logic: latch the request on accept, sequence the access, capture load data.
  // Stores also pass through WAIT so response latency is the same for both directions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ldata_d    = ldata_q;
    len_d      = len_q;
    signed_d   = signed_q;
    fault_d    = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LSU_req_valid) begin
          is_store_d = LSU_req_is_store;
          rd_d       = LSU_req_rd;
          addr_d     = LSU_req_address;
          len_d      = dec_length;
          signed_d   = dec_signed;
          fault_d    = dec_fault;
          wdata_d    = LSU_req_is_store ? mask_store(dec_length, LSU_req_store_data) : '0;
          ldata_d    = '0;
          cnt_d      = '0;
          state_d    = (dec_fault != FAULT_NONE) ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (MEM_LATENCY == 0) begin
          if (!is_store_q) ldata_d = MEM_read_data;
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (!is_store_q) ldata_d = MEM_read_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (LSU_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request/response registers with synchronous reset.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      rd_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ldata_q    <= '0;
      len_q      <= LEN_NONE;
      signed_q   <= 1'b0;
      fault_q    <= FAULT_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ldata_q    <= ldata_d;
      len_q      <= len_d;
      signed_q   <= signed_d;
      fault_q    <= fault_d;
    end
  end

  // Memory port drive, decoded purely from registered state.
  always_comb begin
    MEM_write_length  = LEN_NONE;
    MEM_write_address = '0;
    MEM_write_data    = '0;
    MEM_read_length   = LEN_NONE;
    MEM_read_signed   = 1'b0;
    MEM_read_address  = '0;
    if ((state_q == ST_ACCESS) && is_store_q) begin
      MEM_write_length  = len_q;
      MEM_write_address = addr_q;
      MEM_write_data    = wdata_q;
    end
    if (((state_q == ST_ACCESS) || (state_q == ST_WAIT)) && !is_store_q) begin
      MEM_read_length  = len_q;
      MEM_read_signed  = signed_q;
      MEM_read_address = addr_q;
    end
  end

  assign LSU_req_ready      = (state_q == ST_IDLE);
  assign LSU_resp_valid     = (state_q == ST_RESP);
  assign LSU_resp_load_data = ldata_q;
  assign LSU_resp_rd        = rd_q;
  assign LSU_resp_is_store  = is_store_q;
  assign LSU_resp_fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a zero-latency and a three-cycle-latency instance
// share request inputs; each sees its own little-endian byte memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       req_valid = '0;
  logic             req_is_store = 1'b0;
  logic [2:0]       req_f3 = '0;
  logic [31:0]      req_addr = '0;
  logic [31:0]      req_data = '0;
  logic [4:0]       req_rd = '0;
  logic             resp_ready = 1'b0;

  logic [1:0]       ready, rvalid, ris_st, rsgn;
  logic [1:0][31:0] rdata, wdata_o, waddr, raddr, mrd;
  logic [1:0][4:0]  rrd;
  logic [1:0][1:0]  rfault, wlen, rlen;

  load_store_unit #(.MEM_LATENCY(0), .ALLOW_MISAL(1'b0)) dut0 (
    .SYS_clk(clk), .SYS_reset(rst),
    .LSU_req_valid(req_valid[0]), .LSU_req_ready(ready[0]),
    .LSU_req_is_store(req_is_store), .LSU_req_funct3(req_f3),
    .LSU_req_address(req_addr), .LSU_req_store_data(req_data), .LSU_req_rd(req_rd),
    .LSU_resp_valid(rvalid[0]), .LSU_resp_ready(resp_ready),
    .LSU_resp_load_data(rdata[0]), .LSU_resp_rd(rrd[0]),
    .LSU_resp_is_store(ris_st[0]), .LSU_resp_fault(rfault[0]),
    .MEM_write_length(wlen[0]), .MEM_read_length(rlen[0]), .MEM_read_signed(rsgn[0]),
    .MEM_write_data(wdata_o[0]), .MEM_write_address(waddr[0]),
    .MEM_read_address(raddr[0]), .MEM_read_data(mrd[0])
  );

  load_store_unit #(.MEM_LATENCY(3), .ALLOW_MISAL(1'b0)) dut1 (
    .SYS_clk(clk), .SYS_reset(rst),
    .LSU_req_valid(req_valid[1]), .LSU_req_ready(ready[1]),
    .LSU_req_is_store(req_is_store), .LSU_req_funct3(req_f3),
    .LSU_req_address(req_addr), .LSU_req_store_data(req_data), .LSU_req_rd(req_rd),
    .LSU_resp_valid(rvalid[1]), .LSU_resp_ready(resp_ready),
    .LSU_resp_load_data(rdata[1]), .LSU_resp_rd(rrd[1]),
    .LSU_resp_is_store(ris_st[1]), .LSU_resp_fault(rfault[1]),
    .MEM_write_length(wlen[1]), .MEM_read_length(rlen[1]), .MEM_read_signed(rsgn[1]),
    .MEM_write_data(wdata_o[1]), .MEM_write_address(waddr[1]),
    .MEM_read_address(raddr[1]), .MEM_read_data(mrd[1])
  );

  // ---------------- environment memory ----------------
  logic [7:0] emem [2][1024];
  bit         wmask [2][1024];

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h100: return 8'hEF;
      'h101: return 8'hBE;
      'h102: return 8'hAD;
      'h103: return 8'hDE;
      'h340: return 8'h34;
      'h341: return 8'h92;
      default: return 8'((a * 37 + 11) ^ (a >> 3));
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b01) ? 1 : (len == 2'b10) ? 2 : (len == 2'b11) ? 4 : 0;
  endfunction

  function automatic logic [31:0] env_read(input int s, input logic [31:0] a,
                                           input logic [1:0] len, input logic sgn);
    logic [31:0] v;
    int n, idx;
    v = '0;
    n = nbytes(len);
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        idx = int'((a + 32'(i)) & 32'h3FF);
        v[8*i +: 8] = wmask[s][idx] ? emem[s][idx] : init_byte(idx);
      end
    end
    if (sgn && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sgn && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  logic [31:0] lat_pipe [3];
  assign mrd[0] = env_read(0, raddr[0], rlen[0], rsgn[0]);
  assign mrd[1] = lat_pipe[2];

  always @(posedge clk) begin
    lat_pipe[0] <= env_read(1, raddr[1], rlen[1], rsgn[1]);
    lat_pipe[1] <= lat_pipe[0];
    lat_pipe[2] <= lat_pipe[1];
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes(wlen[s])) begin
          emem[s][int'((waddr[s] + 32'(i)) & 32'h3FF)]  <= wdata_o[s][8*i +: 8];
          wmask[s][int'((waddr[s] + 32'(i)) & 32'h3FF)] <= 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [1024];

  function automatic logic [1:0] ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) return 2'b10;
    sz = 1 << f3[1:0];
    if ((int'(a[1:0]) % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[int'((a + 32'(i)) & 32'h3FF)]) << (8*i));
    if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
    return v;
  endfunction

  function automatic logic [31:0] masked(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return d & 32'h000000FF;
    if (f3 == 3'd1) return d & 32'h0000FFFF;
    return d;
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic run_req(input int sel, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] tag,
                         input int hold,
                         output logic [1:0] flt, output logic [31:0] ld, output logic [4:0] otag,
                         output int lat, output int wcyc, output int rcyc,
                         output logic [31:0] wd_seen, output logic [31:0] ad_seen,
                         output logic sg_seen);
    int guard;
    lat = 0; wcyc = 0; rcyc = 0; wd_seen = '0; ad_seen = '0; sg_seen = 1'b0;
    @(negedge clk);
    guard = 0;
    while (!ready[sel] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(ready[sel]), 32'd1);
    req_is_store = st; req_f3 = f3; req_addr = a; req_data = d; req_rd = tag;
    req_valid[sel] = 1'b1;
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (wlen[sel] != 2'b00) begin wcyc++; wd_seen = wdata_o[sel]; ad_seen = waddr[sel]; end
      if (rlen[sel] != 2'b00) begin rcyc++; ad_seen = raddr[sel]; sg_seen = rsgn[sel]; end
      if (rvalid[sel]) lat = k;
    end
    check("resp_seen", 32'(lat != 0), 32'd1);
    flt = rfault[sel]; ld = rdata[sel]; otag = rrd[sel];
    check("resp_is_store", 32'(ris_st[sel]), 32'(st));
    for (int h = 0; h < hold; h++) begin
      req_valid[sel] = 1'b1;
      @(negedge clk);
      check("hold_valid", 32'(rvalid[sel]), 32'd1);
      check("hold_data", rdata[sel], ld);
      check("hold_fault", 32'(rfault[sel]), 32'(flt));
      check("hold_rd", 32'(rrd[sel]), 32'(otag));
      check("hold_req_ready", 32'(ready[sel]), 32'd0);
      check("hold_rlen", 32'(rlen[sel]), 32'd0);
    end
    req_valid[sel] = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_ready", 32'(ready[sel]), 32'd1);
    check("post_hs_valid", 32'(rvalid[sel]), 32'd0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  efault;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] ef, input logic [31:0] ed);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.data = d; v.efault = ef; v.edata = ed;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  flt;
    logic [31:0] ld, wd, ad;
    logic [4:0]  otag;
    logic        sg, ok, st;
    logic [2:0]  f3;
    logic [31:0] a, d, el;
    logic [1:0]  ef;
    int          lat, wc, rc, cnt;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst%0d_ready", s), 32'(ready[s]), 32'd1);
      check($sformatf("rst%0d_rvalid", s), 32'(rvalid[s]), 32'd0);
      check($sformatf("rst%0d_wlen", s), 32'(wlen[s]), 32'd0);
      check($sformatf("rst%0d_rlen", s), 32'(rlen[s]), 32'd0);
      check($sformatf("rst%0d_waddr", s), waddr[s], 32'd0);
      check($sformatf("rst%0d_raddr", s), raddr[s], 32'd0);
      check($sformatf("rst%0d_wdata", s), wdata_o[s], 32'd0);
      check($sformatf("rst%0d_rdata", s), rdata[s], 32'd0);
      check($sformatf("rst%0d_rfault", s), 32'(rfault[s]), 32'd0);
      check($sformatf("rst%0d_rrd", s), 32'(rrd[s]), 32'd0);
    end

    // directed table, zero-latency instance
    add(0, 3'd2, 32'h100, 32'h0,        2'd0, 32'hDEADBEEF);
    add(1, 3'd0, 32'h101, 32'h77777780, 2'd0, 32'h0);
    add(0, 3'd0, 32'h101, 32'h0,        2'd0, 32'hFFFFFF80);
    add(0, 3'd4, 32'h101, 32'h0,        2'd0, 32'h00000080);
    add(0, 3'd2, 32'h100, 32'h0,        2'd0, 32'hDEAD80EF);
    add(1, 3'd1, 32'h202, 32'h1234ABCD, 2'd0, 32'h0);
    add(0, 3'd5, 32'h202, 32'h0,        2'd0, 32'h0000ABCD);
    add(0, 3'd1, 32'h202, 32'h0,        2'd0, 32'hFFFFABCD);
    add(0, 3'd0, 32'h203, 32'h0,        2'd0, 32'hFFFFFFAB);
    add(0, 3'd2, 32'h102, 32'h0,        2'd1, 32'h0);
    add(0, 3'd3, 32'h100, 32'h0,        2'd2, 32'h0);
    add(0, 3'd3, 32'h103, 32'h0,        2'd2, 32'h0);
    add(1, 3'd4, 32'h200, 32'h55,       2'd2, 32'h0);
    add(1, 3'd1, 32'h201, 32'h55,       2'd1, 32'h0);
    add(1, 3'd2, 32'h204, 32'hCAFEF00D, 2'd0, 32'h0);
    add(0, 3'd2, 32'h204, 32'h0,        2'd0, 32'hCAFEF00D);
    add(0, 3'd5, 32'h206, 32'h0,        2'd0, 32'h0000CAFE);
    add(0, 3'd4, 32'h207, 32'h0,        2'd0, 32'h000000CA);
    add(0, 3'd1, 32'h207, 32'h0,        2'd1, 32'h0);
    add(0, 3'd6, 32'h200, 32'h0,        2'd2, 32'h0);
    add(0, 3'd7, 32'h200, 32'h0,        2'd2, 32'h0);
    add(1, 3'd3, 32'h200, 32'h0,        2'd2, 32'h0);
    add(0, 3'd2, 32'h103, 32'h0,        2'd1, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      ok = (tbl[i].efault == 2'd0);
      run_req(0, tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].data, 5'(i), 0,
              flt, ld, otag, lat, wc, rc, wd, ad, sg);
      check($sformatf("v%0d_fault", i), 32'(flt), 32'(tbl[i].efault));
      check($sformatf("v%0d_data", i), ld, tbl[i].edata);
      check($sformatf("v%0d_rd", i), 32'(otag), 32'(i));
      check($sformatf("v%0d_latency", i), 32'(lat), ok ? 32'd2 : 32'd1);
      check($sformatf("v%0d_wcycles", i), 32'(wc), (tbl[i].st && ok) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_rcycles", i), 32'(rc), (!tbl[i].st && ok) ? 32'd1 : 32'd0);
      if (ok) check($sformatf("v%0d_addr", i), ad, tbl[i].addr);
      if (ok && tbl[i].st) check($sformatf("v%0d_wdata", i), wd, masked(tbl[i].f3, tbl[i].data));
      if (ok && !tbl[i].st)
        check($sformatf("v%0d_signed", i), 32'(sg), 32'(tbl[i].f3 == 3'd0 || tbl[i].f3 == 3'd1));
    end

    // latency 3: LH with writeback stalled for 5 cycles
    run_req(1, 1'b0, 3'd1, 32'h340, 32'h0, 5'd9, 5, flt, ld, otag, lat, wc, rc, wd, ad, sg);
    check("lat3_lh_fault", 32'(flt), 32'd0);
    check("lat3_lh_data", ld, 32'hFFFF9234);
    check("lat3_lh_latency", 32'(lat), 32'd5);
    check("lat3_lh_rcycles", 32'(rc), 32'd4);
    check("lat3_lh_signed", 32'(sg), 32'd1);
    check("lat3_lh_rd", 32'(otag), 32'd9);

    // reset while waiting on memory
    @(negedge clk);
    req_is_store = 1'b0; req_f3 = 3'd1; req_addr = 32'h340; req_rd = 5'd3;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wait_rlen_before_reset", 32'(rlen[1]), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("wait_rst_ready", 32'(ready[1]), 32'd1);
    check("wait_rst_rvalid", 32'(rvalid[1]), 32'd0);
    check("wait_rst_rlen", 32'(rlen[1]), 32'd0);
    check("wait_rst_raddr", raddr[1], 32'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvalid[1] || rlen[1] != 2'b00) cnt++;
    end
    check("wait_rst_no_resp", 32'(cnt), 32'd0);

    // reset coinciding with a store offer: nothing accepted, nothing written
    @(negedge clk);
    req_is_store = 1'b1; req_f3 = 3'd2; req_addr = 32'h120; req_data = 32'h11223344;
    req_valid[0] = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 begin req_valid[0] = 1'b0; rst = 1'b0; end
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (wlen[0] != 2'b00 || rvalid[0]) cnt++;
    end
    check("rst_store_no_activity", 32'(cnt), 32'd0);
    check("rst_store_mem_untouched", 32'(wmask[0][32'h120]), 32'd0);
    check("rst_store_ready", 32'(ready[0]), 32'd1);

    // randomized traffic against the reference model, latency-3 instance
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h300 + 32'($urandom_range(0, 59));
      d  = $urandom;
      ef = ref_fault(st, f3, a);
      el = (!st && ef == 2'b00) ? ref_load(f3, a) : 32'h0;
      run_req(1, st, f3, a, d, 5'(n), 0, flt, ld, otag, lat, wc, rc, wd, ad, sg);
      check($sformatf("r%0d_fault", n), 32'(flt), 32'(ef));
      check($sformatf("r%0d_data", n), ld, el);
      check($sformatf("r%0d_latency", n), 32'(lat), (ef == 2'b00) ? 32'd5 : 32'd1);
      check($sformatf("r%0d_rcycles", n), 32'(rc), (!st && ef == 2'b00) ? 32'd4 : 32'd0);
      check($sformatf("r%0d_wcycles", n), 32'(wc), (st && ef == 2'b00) ? 32'd1 : 32'd0);
      if (st && ef == 2'b00) begin
        for (int i = 0; i < (1 << f3[1:0]); i++)
          ref_mem[int'((a + 32'(i)) & 32'h3FF)] = d[8*i +: 8];
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
